mem_arbiter: RTL and testbench

Shares the single NPC memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It sits between those two units and the memory interface. It grants one transaction at a time using two-way round-robin, registers the granted request, drives it to memory, and routes the response back to its owner.

---
 rtl/npc_bus_pkg.sv | 18 +
 rtl/rr_arbiter2.sv | 38 +++
 rtl/mem_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/npc_bus_pkg.sv
// Shared types for the NPC memory-bus arbiter: FSM states, transaction owner
// and store-mask width.
package npc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_IFU = 1'b0,
        OWNER_LSU = 1'b1
    } owner_t;

    localparam int WMASK_W = 8;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant between IFU and LSU. last_owner records the most
// recent winner, so a tie goes to the other requester.
module rr_arbiter2
    import npc_bus_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_ifu,
    input  logic req_lsu,
    input  logic en,
    output logic gnt_ifu,
    output logic gnt_lsu
);

    owner_t last_owner_q;
    owner_t last_owner_d;

    always_comb begin
        gnt_ifu      = req_ifu && (!req_lsu || (last_owner_q == OWNER_LSU));
        gnt_lsu      = req_lsu && (!req_ifu || (last_owner_q == OWNER_IFU));
        last_owner_d = last_owner_q;
        if (en && gnt_ifu) begin
            last_owner_d = OWNER_IFU;
        end else if (en && gnt_lsu) begin
            last_owner_d = OWNER_LSU;
        end
    end

    // Resetting to LSU hands the first tie after reset to the IFU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= OWNER_LSU;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between IFU and LSU: one transaction in flight,
// request fields registered toward memory, response routed back to its owner.
module mem_arbiter
    import npc_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_resp_valid,
    output logic [DATA_WIDTH-1:0] ifu_rdata,

    input  logic                  lsu_req_valid,
    output logic                  lsu_req_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_addr,
    input  logic                  lsu_wen,
    input  logic [DATA_WIDTH-1:0] lsu_wdata,
    input  logic [WMASK_W-1:0]    lsu_wmask,
    output logic                  lsu_resp_valid,
    output logic [DATA_WIDTH-1:0] lsu_rdata,

    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wen,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [WMASK_W-1:0]    mem_wmask,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    arb_state_t            state_q, state_d;
    owner_t                owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [WMASK_W-1:0]    wmask_q, wmask_d;
    logic                  mem_req_valid_q, mem_req_valid_d;

    logic in_idle;
    logic arb_en;
    logic gnt_ifu;
    logic gnt_lsu;
    logic resp_fire;

    assign in_idle = (state_q == IDLE);
    assign arb_en  = in_idle && (ifu_req_valid || lsu_req_valid);

    rr_arbiter2 u_rr (
        .clk     (clk),
        .rst     (rst),
        .req_ifu (ifu_req_valid),
        .req_lsu (lsu_req_valid),
        .en      (arb_en),
        .gnt_ifu (gnt_ifu),
        .gnt_lsu (gnt_lsu)
    );

    // Ready is gated by rst so nothing looks accepted while reset is held.
    assign ifu_req_ready = rst && in_idle && gnt_ifu;
    assign lsu_req_ready = rst && in_idle && gnt_lsu;

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        addr_d          = addr_q;
        wen_d           = wen_q;
        wdata_d         = wdata_q;
        wmask_d         = wmask_q;
        mem_req_valid_d = mem_req_valid_q;
        case (state_q)
            IDLE: begin
                if (gnt_ifu) begin
                    owner_d         = OWNER_IFU;
                    addr_d          = ifu_addr;
                    wen_d           = 1'b0;
                    wdata_d         = '0;
                    wmask_d         = '0;
                    mem_req_valid_d = 1'b1;
                    state_d         = REQ;
                end else if (gnt_lsu) begin
                    owner_d         = OWNER_LSU;
                    addr_d          = lsu_addr;
                    wen_d           = lsu_wen;
                    wdata_d         = lsu_wdata;
                    wmask_d         = lsu_wmask;
                    mem_req_valid_d = 1'b1;
                    state_d         = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    state_d         = RESP;
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                mem_req_valid_d = 1'b0;
                state_d         = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= IDLE;
            owner_q         <= OWNER_IFU;
            addr_q          <= '0;
            wen_q           <= 1'b0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            mem_req_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            addr_q          <= addr_d;
            wen_q           <= wen_d;
            wdata_q         <= wdata_d;
            wmask_q         <= wmask_d;
            mem_req_valid_q <= mem_req_valid_d;
        end
    end

    assign mem_req_valid = mem_req_valid_q;
    assign mem_addr      = addr_q;
    assign mem_wen       = wen_q;
    assign mem_wdata     = wdata_q;
    assign mem_wmask     = wmask_q;

    // Responses outside RESP are dropped; stores return zero data.
    assign resp_fire      = (state_q == RESP) && mem_resp_valid;
    assign ifu_resp_valid = resp_fire && (owner_q == OWNER_IFU);
    assign lsu_resp_valid = resp_fire && (owner_q == OWNER_LSU);
    assign ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
    assign lsu_rdata      = (lsu_resp_valid && !wen_q) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, cycle-by-cycle checks of mem_arbiter: a vector table for the basic
// fetch/store flow, plus sequences for alternation, wait states and reset.
module tb_mem_arbiter;

    typedef struct packed {
        logic        rst;
        logic        iv;
        logic [31:0] ia;
        logic        lv;
        logic [31:0] la;
        logic        lw;
        logic [31:0] wd;
        logic [7:0]  wm;
        logic        mrr;
        logic        mrsv;
        logic [31:0] mrd;
    } in_t;

    typedef struct packed {
        logic        ir;
        logic        lr;
        logic        mrv;
        logic [31:0] ma;
        logic        mw;
        logic [31:0] mwd;
        logic [7:0]  mwm;
        logic        irv;
        logic [31:0] ird;
        logic        lrv;
        logic [31:0] lrd;
    } out_t;

    typedef struct {
        string name;
        in_t   i;
        out_t  o;
    } vec_t;

    localparam logic [31:0] A0 = 32'h8000_0000;
    localparam logic [31:0] A1 = 32'h8000_1000;
    localparam logic [31:0] D0 = 32'h0000_0413;
    localparam logic [31:0] WD = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_addr       (lsu_addr),
        .lsu_wen        (lsu_wen),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_addr       (mem_addr),
        .mem_wen        (mem_wen),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    function automatic in_t mk_in(input logic r, input logic iv, input logic [31:0] ia,
                                  input logic lv, input logic [31:0] la, input logic lw,
                                  input logic [31:0] wd, input logic [7:0] wm,
                                  input logic mrr, input logic mrsv, input logic [31:0] mrd);
        mk_in = {r, iv, ia, lv, la, lw, wd, wm, mrr, mrsv, mrd};
    endfunction

    function automatic out_t mk_out(input logic ir, input logic lr, input logic mrv,
                                    input logic [31:0] ma, input logic mw,
                                    input logic [31:0] mwd, input logic [7:0] mwm,
                                    input logic irv, input logic [31:0] ird,
                                    input logic lrv, input logic [31:0] lrd);
        mk_out = {ir, lr, mrv, ma, mw, mwd, mwm, irv, ird, lrv, lrd};
    endfunction

    // Drive one cycle's inputs at the falling edge, compare outputs 1 time unit later.
    task automatic cyc(input string name, input in_t i, input out_t e);
        out_t a;
        @(negedge clk);
        rst            = i.rst;
        ifu_req_valid  = i.iv;
        ifu_addr       = i.ia;
        lsu_req_valid  = i.lv;
        lsu_addr       = i.la;
        lsu_wen        = i.lw;
        lsu_wdata      = i.wd;
        lsu_wmask      = i.wm;
        mem_req_ready  = i.mrr;
        mem_resp_valid = i.mrsv;
        mem_rdata      = i.mrd;
        #1;
        a = {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_addr, mem_wen, mem_wdata,
             mem_wmask, ifu_resp_valid, ifu_rdata, lsu_resp_valid, lsu_rdata};
        n_vec++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, a, e);
        end
    endtask

    vec_t        tbl [9];
    logic        wi;
    logic [31:0] ia, la, rd, ea, ewd;
    logic        ew;
    logic [7:0]  ewm;

    initial begin
        rst = 1'b0;
        ifu_req_valid = 1'b0; ifu_addr = '0;
        lsu_req_valid = 1'b0; lsu_addr = '0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;

        tbl[0] = '{"reset",     mk_in(0,0,0,0,0,0,0,0,0,0,0),              mk_out(0,0,0,0,0,0,0,0,0,0,0)};
        tbl[1] = '{"idle",      mk_in(1,0,0,0,0,0,0,0,0,0,0),              mk_out(0,0,0,0,0,0,0,0,0,0,0)};
        tbl[2] = '{"spur_idle", mk_in(1,0,0,0,0,0,0,0,0,1,32'hFFFF_FFFF),  mk_out(0,0,0,0,0,0,0,0,0,0,0)};
        tbl[3] = '{"ifu_hs",    mk_in(1,1,A0,0,0,0,0,0,1,0,0),             mk_out(1,0,0,0,0,0,0,0,0,0,0)};
        tbl[4] = '{"ifu_req",   mk_in(1,1,A0,1,A1,0,0,0,1,0,0),            mk_out(0,0,1,A0,0,0,0,0,0,0,0)};
        tbl[5] = '{"ifu_resp",  mk_in(1,0,0,0,0,0,0,0,0,1,D0),             mk_out(0,0,0,A0,0,0,0,1,D0,0,0)};
        tbl[6] = '{"lsu_hs",    mk_in(1,0,0,1,A1,1,WD,8'h0F,0,0,0),        mk_out(0,1,0,A0,0,0,0,0,0,0,0)};
        tbl[7] = '{"lsu_req",   mk_in(1,0,0,0,0,0,0,0,1,0,0),              mk_out(0,0,1,A1,1,WD,8'h0F,0,0,0,0)};
        tbl[8] = '{"lsu_resp",  mk_in(1,0,0,0,0,0,0,0,0,1,32'h1234_5678),  mk_out(0,0,0,A1,1,WD,8'h0F,0,0,1,0)};

        for (int v = 0; v < 9; v++) begin
            cyc(tbl[v].name, tbl[v].i, tbl[v].o);
        end

        // Both requesters held valid: grants must alternate IFU, LSU, IFU, LSU.
        ea = A1; ew = 1'b1; ewd = WD; ewm = 8'h0F;
        for (int g = 0; g < 4; g++) begin
            wi = (g % 2 == 0);
            ia = A0 + 32'(16 * g);
            la = A1 + 32'(16 * g);
            rd = 32'h5000_0000 + 32'(g);
            cyc($sformatf("alt%0d_hs", g), mk_in(1,1,ia,1,la,0,0,0,0,0,0),
                mk_out(wi,!wi,0,ea,ew,ewd,ewm,0,0,0,0));
            ea = wi ? ia : la; ew = 1'b0; ewd = '0; ewm = '0;
            cyc($sformatf("alt%0d_req", g), mk_in(1,1,ia,1,la,0,0,0,1,0,0),
                mk_out(0,0,1,ea,0,0,0,0,0,0,0));
            cyc($sformatf("alt%0d_resp", g), mk_in(1,1,ia,1,la,0,0,0,0,1,rd),
                mk_out(0,0,0,ea,0,0,0,wi,wi ? rd : 32'h0,!wi,wi ? 32'h0 : rd));
        end

        // Memory stalls the request 3 cycles and the response 1 extra cycle.
        ia = A0 + 32'h100;
        rd = 32'h0000_0013;
        cyc("wait_hs", mk_in(1,1,ia,0,0,0,0,0,0,0,0), mk_out(1,0,0,ea,0,0,0,0,0,0,0));
        ea = ia;
        for (int k = 0; k < 3; k++) begin
            cyc($sformatf("wait_stall%0d", k), mk_in(1,0,0,1,A1,1,WD,8'h0F,0,(k == 1),32'hBAD0_0000),
                mk_out(0,0,1,ea,0,0,0,0,0,0,0));
        end
        cyc("wait_accept", mk_in(1,0,0,1,A1,1,WD,8'h0F,1,0,0), mk_out(0,0,1,ea,0,0,0,0,0,0,0));
        cyc("wait_resp0",  mk_in(1,0,0,1,A1,1,WD,8'h0F,0,0,0), mk_out(0,0,0,ea,0,0,0,0,0,0,0));
        cyc("wait_resp1",  mk_in(1,0,0,1,A1,1,WD,8'h0F,0,1,rd), mk_out(0,0,0,ea,0,0,0,1,rd,0,0));
        cyc("wait_idle_spur", mk_in(1,0,0,0,0,0,0,0,0,1,32'hBAD1_0000), mk_out(0,0,0,ea,0,0,0,0,0,0,0));

        // Reset while waiting in RESP, then IFU must take the first tie.
        la = A1 + 32'h200;
        cyc("rst_hs",   mk_in(1,1,A0,1,la,1,WD,8'h0F,0,0,0), mk_out(0,1,0,ea,0,0,0,0,0,0,0));
        cyc("rst_req",  mk_in(1,1,A0,1,la,1,WD,8'h0F,1,0,0), mk_out(0,0,1,la,1,WD,8'h0F,0,0,0,0));
        cyc("rst_wait", mk_in(1,1,A0,1,la,1,WD,8'h0F,0,0,0), mk_out(0,0,0,la,1,WD,8'h0F,0,0,0,0));
        cyc("rst_assert", mk_in(0,1,A0,1,la,1,WD,8'h0F,0,1,32'h7777_7777), mk_out(0,0,0,0,0,0,0,0,0,0,0));
        cyc("rst_release_tie", mk_in(1,1,A0,1,la,1,WD,8'h0F,0,0,0), mk_out(1,0,0,0,0,0,0,0,0,0,0));
        cyc("rst_ifu_req",  mk_in(1,0,0,0,0,0,0,0,1,0,0), mk_out(0,0,1,A0,0,0,0,0,0,0,0));
        cyc("rst_ifu_resp", mk_in(1,0,0,0,0,0,0,0,0,1,32'h0000_0417), mk_out(0,0,0,A0,0,0,0,1,32'h0000_0417,0,0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
